// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types and helpers for the main-memory bus arbiter
package arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    localparam int MASTER_ICACHE = 0;
    localparam int MASTER_DCACHE = 1;
    localparam int MASTER_DEBUG  = 2;

    // Width needed for a counter running 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick starting after the last grant
module rr_priority_picker #(
    parameter int NUM_MASTERS = 3,
    localparam int IW = (NUM_MASTERS <= 1) ? 1 : $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IW-1:0]          i_last,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic [IW-1:0]          o_idx,
    output logic                   o_valid
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        return IW'((int'(base) + off) % NUM_MASTERS);
    endfunction

    // Scan farthest offset first so the nearest requester after i_last overrides.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int off = NUM_MASTERS; off >= 1; off--) begin
            if (i_req[wrap_idx(i_last, off)]) begin
                o_grant                         = '0;
                o_grant[wrap_idx(i_last, off)]  = 1'b1;
                o_idx                           = wrap_idx(i_last, off);
                o_valid                         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - round-robin single-outstanding arbiter for the main-memory slave port
module memory_bus_arbiter
    import arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_MASTERS-1:0]              m_req,
    input  logic [NUM_MASTERS-1:0]              m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb,
    output logic [NUM_MASTERS-1:0]              m_ack,
    output logic [NUM_MASTERS-1:0]              m_err,
    output logic [DATA_WIDTH-1:0]               m_rdata,
    output logic                                s_stb,
    output logic                                s_we,
    output logic [ADDR_WIDTH-1:0]               s_addr,
    output logic [DATA_WIDTH-1:0]               s_wdata,
    output logic [DATA_WIDTH/8-1:0]             s_wstrb,
    input  logic                                s_ack,
    input  logic [DATA_WIDTH-1:0]               s_rdata,
    output logic [NUM_MASTERS-1:0]              grant,
    output logic                                busy
);

    localparam int IW      = (NUM_MASTERS <= 1) ? 1 : $clog2(NUM_MASTERS);
    localparam int SW      = DATA_WIDTH / 8;
    localparam int CW      = cnt_width(TIMEOUT_CYCLES);
    localparam int TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    arb_state_t                r_state;
    arb_state_t                w_next_state;
    logic [IW-1:0]             r_last;
    logic [NUM_MASTERS-1:0]    r_grant;
    logic                      r_we;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [SW-1:0]             r_wstrb;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_err;
    logic [CW-1:0]             r_cnt;

    logic [NUM_MASTERS-1:0]    w_pick_grant;
    logic [IW-1:0]             w_pick_idx;
    logic                      w_pick_valid;
    logic                      w_timeout;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .i_req   (m_req),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TO_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE:   if (w_pick_valid) w_next_state = ARB_ACCESS;
            ARB_ACCESS: if (s_ack || w_timeout) w_next_state = ARB_RESP;
            ARB_RESP:   w_next_state = ARB_IDLE;
            default:    w_next_state = ARB_IDLE;
        endcase
    end

    // Command is latched at grant so the slave sees it unchanged for the whole access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= IW'(NUM_MASTERS - 1);
            r_grant <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_cnt <= '0;
                    if (w_pick_valid) begin
                        r_grant <= w_pick_grant;
                        r_last  <= w_pick_idx;
                        r_we    <= m_we[w_pick_idx];
                        r_addr  <= m_addr[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata <= m_wdata[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        r_wstrb <= m_wstrb[w_pick_idx*SW +: SW];
                    end
                end
                ARB_ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (s_ack) begin
                        r_rdata <= s_rdata;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                ARB_RESP: r_grant <= '0;
                default:  r_grant <= '0;
            endcase
        end
    end

    always_comb begin
        s_stb = (r_state == ARB_ACCESS);
        busy  = (r_state != ARB_IDLE);
        m_ack = '0;
        m_err = '0;
        if (r_state == ARB_RESP) begin
            m_ack = r_grant;
            m_err = r_err ? r_grant : '0;
        end
    end

    assign s_we    = r_we;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata;
    assign s_wstrb = r_wstrb;
    assign m_rdata = r_rdata;
    assign grant   = r_grant;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb/tb_memory_bus_arbiter.sv - self-checking bench for memory_bus_arbiter
module tb_memory_bus_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NM-1:0]       m_req;
    logic [NM-1:0]       m_we;
    logic [NM*AW-1:0]    m_addr;
    logic [NM*DW-1:0]    m_wdata;
    logic [NM*SW-1:0]    m_wstrb;
    logic [NM-1:0]       m_ack;
    logic [NM-1:0]       m_err;
    logic [DW-1:0]       m_rdata;
    logic                s_stb;
    logic                s_we;
    logic [AW-1:0]       s_addr;
    logic [DW-1:0]       s_wdata;
    logic [SW-1:0]       s_wstrb;
    logic                s_ack;
    logic [DW-1:0]       s_rdata;
    logic [NM-1:0]       grant;
    logic                busy;

    int checks = 0;
    int errors = 0;

    int          last_g;
    int          served;
    int          obs_w;
    logic        q_we    [NM];
    logic [31:0] q_addr  [NM];
    logic [31:0] q_wdata [NM];
    logic [3:0]  q_wstrb [NM];

    always #5 clk = ~clk;

    memory_bus_arbiter #(
        .NUM_MASTERS    (NM),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_stb   (s_stb),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_ack   (s_ack),
        .s_rdata (s_rdata),
        .grant   (grant),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    // Round-robin rule: first requester found going upward from the previous winner.
    function automatic int pick(input int last, input logic [NM-1:0] req);
        for (int k = 1; k <= NM; k++) begin
            if (req[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    task automatic set_cmd(input int m, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] st);
        q_we[m]    = we;
        q_addr[m]  = a;
        q_wdata[m] = d;
        q_wstrb[m] = st;
        m_we[m]    = we;
        m_addr[m*AW +: AW]  = a;
        m_wdata[m*DW +: DW] = d;
        m_wstrb[m*SW +: SW] = st;
        m_req[m]   = 1'b1;
    endtask

    task automatic rand_cmd(input int m);
        set_cmd(m, 1'($urandom), $urandom, $urandom, 4'($urandom));
    endtask

    // Called at a falling edge with the DUT idle and at least one request raised.
    // ack_at = ACCESS cycle in which the slave acks; 0 or >TO means never.
    task automatic do_txn(input int ack_at, input logic [31:0] data);
        int  w;
        bit  timed_out;
        logic [NM-1:0] others;
        w         = pick(last_g, m_req);
        others    = m_req & ~(NM'(1) << w);
        timed_out = (ack_at < 1) || (ack_at > TO);
        step();
        obs_w = -1;
        for (int i = 0; i < NM; i++) if (grant === (NM'(1) << i)) obs_w = i;
        chk("grant", grant, NM'(1) << w);
        if (served >= 0 && others != 0)
            chk("rr_fair", 64'(obs_w != served), 64'd1);
        for (int c = 1; c <= TO; c++) begin
            chk("s_stb_access", s_stb, 1'b1);
            chk("busy_access", busy, 1'b1);
            chk("s_we", s_we, q_we[w]);
            chk("s_addr", s_addr, q_addr[w]);
            chk("s_wdata", s_wdata, q_wdata[w]);
            chk("s_wstrb", s_wstrb, q_wstrb[w]);
            chk("m_ack_access", m_ack, '0);
            if (c == ack_at) begin
                s_ack   = 1'b1;
                s_rdata = data;
            end
            step();
            s_ack   = 1'b0;
            s_rdata = ~data;
            if (c == ack_at) break;
        end
        chk("s_stb_resp", s_stb, 1'b0);
        chk("m_ack", m_ack, NM'(1) << w);
        chk("m_err", m_err, timed_out ? (NM'(1) << w) : '0);
        chk("m_rdata", m_rdata, timed_out ? 32'h0 : data);
        m_req[w] = 1'b0;
        last_g   = w;
        served   = w;
        step();
        chk("m_ack_idle", m_ack, '0);
        chk("grant_idle", grant, '0);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        int exp_seq [5];
        int guard;
        exp_seq = '{0, 1, 2, 0, 1};
        rst_n   = 1'b0;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ack   = 1'b0;
        s_rdata = '0;
        last_g  = NM - 1;
        served  = -1;
        obs_w   = -1;

        step();
        step();
        chk("rst_outputs", {m_ack, m_err, s_stb, s_we, grant, busy}, '0);
        chk("rst_bus", {s_addr, s_wdata}, '0);
        chk("rst_rdata", m_rdata, '0);
        rst_n = 1'b1;
        step();

        for (int m = 0; m < NM; m++) rand_cmd(m);
        for (int i = 0; i < 5; i++) begin
            do_txn(1, $urandom);
            chk("rr_seq", 64'(obs_w), 64'(exp_seq[i]));
            rand_cmd(last_g);
        end
        guard = 0;
        while (m_req != 0 && guard < 10) begin
            do_txn(1, $urandom);
            guard++;
        end
        step();
        step();
        chk("idle_no_req", {grant, s_stb, busy}, '0);

        set_cmd(MASTER_ICACHE_IDX(), 1'b0, 32'h100, 32'h0, 4'h0);
        do_txn(1, 32'hDEADBEEF);
        set_cmd(1, 1'b1, 32'h2004, 32'hCAFEF00D, 4'b0011);
        do_txn(3, 32'h1234_5678);
        set_cmd(2, 1'b0, 32'h3000, 32'h0, 4'hF);
        do_txn(0, 32'h5555_AAAA);
        set_cmd(0, 1'b0, 32'h104, 32'h0, 4'h0);
        do_txn(TO, 32'hA5A5_0F0F);

        for (int t = 0; t < 40; t++) begin
            for (int m = 0; m < NM; m++)
                if (!m_req[m] && $urandom_range(0, 1) == 1) rand_cmd(m);
            if (m_req == 0) rand_cmd($urandom_range(0, NM - 1));
            do_txn($urandom_range(0, TO + 1), $urandom);
        end
        guard = 0;
        while (m_req != 0 && guard < 10) begin
            do_txn($urandom_range(1, TO), $urandom);
            guard++;
        end

        set_cmd(2, 1'b1, 32'h4000, 32'h0BAD_F00D, 4'hF);
        step();
        chk("rst_pre_grant", grant, 3'b100);
        rst_n = 1'b0;
        #1;
        chk("rst_async_stb", s_stb, 1'b0);
        chk("rst_async_grant", grant, '0);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_ack", m_ack, '0);
        set_cmd(0, 1'b0, 32'h200, 32'h0, 4'h0);
        step();
        chk("rst_hold_ack", m_ack, '0);
        step();
        rst_n  = 1'b1;
        last_g = NM - 1;
        served = -1;
        do_txn(1, $urandom);
        chk("rst_winner", 64'(obs_w), 64'd0);
        do_txn(2, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic int MASTER_ICACHE_IDX();
        return 0;
    endfunction

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares the SoC's single main-memory slave port between NUM_MASTERS requesters: I-cache refill, D-cache refill/writeback, and UART debug loader.
- Round-robin arbitration with one outstanding transaction at a time.
- A per-access timeout converts a hung slave into an error response.
- Sits between the cache controllers and the on-chip memory/peripheral bus inside Grande_Risco_5_SOC.

Parameters:
- NUM_MASTERS, 3, number of requesters; index 0 = I-cache, 1 = D-cache, 2 = debug loader.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width.
- TIMEOUT_CYCLES, 256, ACCESS cycles without s_ack before an error is returned; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_req  in  NUM_MASTERS  per-master request, held until its m_ack
- m_we  in  NUM_MASTERS  per-master write enable
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at slice i
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_wstrb  in  NUM_MASTERS*(DATA_WIDTH/8)  packed byte strobes
- m_ack  out  NUM_MASTERS  one-cycle completion pulse to the served master
- m_err  out  NUM_MASTERS  error flag, valid only with m_ack
- m_rdata  out  DATA_WIDTH  shared read data, valid only with m_ack
- s_stb  out  1  slave access strobe
- s_we  out  1  slave write enable
- s_addr  out  ADDR_WIDTH  slave address
- s_wdata  out  DATA_WIDTH  slave write data
- s_wstrb  out  DATA_WIDTH/8  slave byte strobes
- s_ack  in  1  slave completion, one cycle
- s_rdata  in  DATA_WIDTH  slave read data, valid with s_ack
- grant  out  NUM_MASTERS  one-hot current owner; 0 when idle
- busy  out  1  high in ACCESS or RESP

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: all outputs 0; state IDLE; last_grant = NUM_MASTERS-1, so master 0 has first priority.
- IDLE:
  - If any m_req is set, choose the first set bit scanning from last_grant+1 upward with wrap-around.
  - Register grant, last_grant and the chosen master's we/addr/wdata/wstrb, then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - s_stb=1 with the registered command; outputs are stable for the whole state.
  - Timeout counter is cleared on entry and increments each cycle.
  - On s_ack: capture s_rdata, err=0, go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter == TIMEOUT_CYCLES-1: rdata=0, err=1, s_stb drops, go to RESP.
  - s_ack and timeout in the same cycle: s_ack wins.
- RESP:
  - m_ack[owner]=1 and m_err[owner]=err for exactly one cycle; m_rdata = captured data.
  - Then go to IDLE and clear grant.
- Latency: minimum 3 cycles from m_req sampled to m_ack (IDLE, ACCESS with immediate s_ack, RESP). Maximum transaction length is TIMEOUT_CYCLES+2.
- Handshake: the master deasserts m_req at the edge ending its m_ack cycle. The IDLE cycle after RESP therefore never sees a stale request.
- m_req dropped during ACCESS is illegal. The transaction still completes and m_ack is still pulsed.
- Fairness: a continuously requesting master is served at most once per NUM_MASTERS grants while others are pending.
- m_rdata holds its last value outside RESP; it is don't-care.
- s_ack seen in IDLE or RESP is ignored.
- Reset asserted mid-transaction: immediate return to reset values; no m_ack is issued for the aborted access.

Decomposition:
- Shared package arbiter_pkg holds:
  - state enum arb_state_t {ARB_IDLE, ARB_ACCESS, ARB_RESP};
  - master index constants MASTER_ICACHE=0, MASTER_DCACHE=1, MASTER_DEBUG=2;
  - function clog2-based counter width helper.
- One natural sub-module: rr_priority_picker.
  - Combinational; inputs req vector and last_grant index; outputs one-hot next grant and its index.
  - Parameterised by NUM_MASTERS so it can be reused by the peripheral bus.

Test Plan:
- Single read: m_req=3'b001, addr 0x100, slave acks in its first ACCESS cycle with 0xDEADBEEF -> s_stb high 1 cycle; m_ack=3'b001 exactly 3 cycles after request; m_rdata=0xDEADBEEF, m_err=0.
- Round-robin: all three masters request continuously, acks immediate -> grant sequence 001, 010, 100, 001, 010; no master served twice in a row.
- Write passthrough: master 1 writes 0xCAFEF00D, wstrb 4'b0011, addr 0x2004 -> slave sees exactly those values for the whole ACCESS; master 1 gets m_ack, others stay 0.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> s_stb high exactly 4 cycles; then m_ack with m_err=1 and m_rdata=0; next request is granted normally.
- Ack/timeout collision: s_ack in the 4th ACCESS cycle with TIMEOUT_CYCLES=4 -> m_err=0 and read data is returned.
- Reset mid-ACCESS: rst_n low during a master 2 access -> s_stb, grant, busy and m_ack go 0 asynchronously; after release master 0 wins against a simultaneous master 2 request.
